// File: rtl/race_pkg.sv
// race_pkg: definitions shared by the race handshake chain
// (race_marshal -> race_official -> race_observer).
//   race_state_e  : marshal FSM states, encoded 2'd0..2'd3
//   LFSR_TAPS_W8  : Galois tap mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
package race_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } race_state_e;

  localparam logic [7:0] LFSR_TAPS_W8 = 8'hB8;

endpackage

// File: rtl/race_marshal_if.sv
// race_marshal_if: handshake bundle between race_marshal and the rest of the chain.
//   start, done            : chain -> marshal
//   ready, race_count,
//   busy, timeout          : marshal -> chain
// Modports: master = race_marshal side, slave = official/observer/bench side.
interface race_marshal_if
  import race_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic             done;
  logic             ready;
  logic [CNT_W-1:0] race_count;
  logic             busy;
  logic             timeout;

  modport master (
    input  start, done,
    output ready, race_count, busy, timeout
  );

  modport slave (
    output start, done,
    input  ready, race_count, busy, timeout
  );

endinterface

// File: rtl/race_lfsr.sv
// race_lfsr: free-running Galois LFSR, advances every cycle out of reset.
// A zero SEED is replaced by 1 so the register can never lock up at 0.
// Ports: clk (rising edge), rst_l (async, active-low), q (current state).
module race_lfsr
  import race_pkg::*;
#(
  parameter int                LFSR_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst_l,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(LFSR_TAPS_W8);
  localparam logic [LFSR_W-1:0] ONE     = LFSR_W'(1'b1);
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next state: shift right, fold the tap mask in when a 1 falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ TAPS;
    end else begin
      lfsr_d = lfsr_d;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lfsr_q <= SEED_NZ;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/race_marshal.sv
// race_marshal: upstream stage of the race handshake chain.
// Waits for the chain to be idle (start=0, done=0), waits a randomised delay
// D = MIN_DELAY + (lfsr & DELAY_MASK), raises ready, holds it until start,
// counts the launched race, then waits for done before re-arming.
// Ports: clk, rst_l (async active-low), bus (race_marshal_if.master:
//   start/done in; ready/race_count/busy/timeout out, all registered).
// Optional feature: define RACE_MARSHAL_TIMEOUT_EN to add a READY watchdog
// that drops ready and pulses timeout after TIMEOUT cycles without start.
module race_marshal
  import race_pkg::*;
#(
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(8'hA5),
  parameter int                MIN_DELAY  = 4,
  parameter logic [LFSR_W-1:0] DELAY_MASK = LFSR_W'(8'h0F),
  parameter int                CNT_W      = 16,
  parameter int                TIMEOUT    = 32
) (
  input  logic          clk,
  input  logic          rst_l,
  race_marshal_if.master bus
);

  // Reject parameter sets the counters cannot represent.
  if (TIMEOUT < 1 || MIN_DELAY < 0 || MIN_DELAY > (1 << LFSR_W)) begin : g_bad_param
    $error("race_marshal: TIMEOUT or MIN_DELAY out of range");
  end

  logic [LFSR_W-1:0] lfsr_s;
  logic [LFSR_W:0]   delay_s;

  race_state_e       state_q, state_d;
  logic [LFSR_W:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  race_count_q, race_count_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

`ifdef RACE_MARSHAL_TIMEOUT_EN
  localparam int            WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  race_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_l (rst_l),
    .q     (lfsr_s)
  );

  // One extra bit so MIN_DELAY plus the full mask cannot overflow.
  assign delay_s = (LFSR_W + 1)'(MIN_DELAY) + {1'b0, lfsr_s & DELAY_MASK};

  // Next-state and registered-output logic for the handshake FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = 1'b0;
    race_count_d = race_count_q;
    timeout_d    = 1'b0;
`ifdef RACE_MARSHAL_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    case (state_q)
      IDLE: begin
        // Re-arm only once the whole chain has gone quiet.
        if (!bus.start && !bus.done) begin
          cnt_d   = delay_s;
          state_d = DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (bus.start || bus.done) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = READY;
`ifdef RACE_MARSHAL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q - (LFSR_W + 1)'(1'b1);
        end
      end
      READY: begin
        // start wins over a coincident done; that done is not acted on here.
        if (bus.start) begin
          race_count_d = race_count_q + CNT_W'(1'b1);
          state_d      = RUN;
`ifdef RACE_MARSHAL_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d    = wd_q + WD_W'(1'b1);
          ready_d = 1'b1;
`else
        end else begin
          ready_d = 1'b1;
`endif
        end
      end
      RUN: begin
        if (bus.done) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      race_count_q <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef RACE_MARSHAL_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      race_count_q <= race_count_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
`ifdef RACE_MARSHAL_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign bus.ready      = ready_q;
  assign bus.race_count = race_count_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_race_marshal.sv
// tb_race_marshal: self-checking bench for race_marshal.
// dut_fix: MIN_DELAY=4, DELAY_MASK=0, TIMEOUT=8 -> every delay is exactly 4.
// dut_rnd: default delay parameters, CNT_W=4 -> wrap and random-delay checks.
module tb_race_marshal;

  logic clk = 1'b0;
  logic rst_fix_l;
  logic rst_rnd_l;

  always #5 clk = ~clk;

  race_marshal_if #(.CNT_W(16)) fix_if ();
  race_marshal_if #(.CNT_W(4))  rnd_if ();

  race_marshal #(
    .MIN_DELAY  (4),
    .DELAY_MASK (8'h00),
    .CNT_W      (16),
    .TIMEOUT    (8)
  ) dut_fix (
    .clk   (clk),
    .rst_l (rst_fix_l),
    .bus   (fix_if.master)
  );

  race_marshal #(
    .CNT_W (4)
  ) dut_rnd (
    .clk   (clk),
    .rst_l (rst_rnd_l),
    .bus   (rnd_if.master)
  );

  typedef struct {
    logic        s;
    logic        d;
    logic        exp_ready;
    logic        exp_busy;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic d, input logic r, input logic b, input logic [15:0] c);
    vec_t v;
    v.s = s; v.d = d; v.exp_ready = r; v.exp_busy = b; v.exp_count = c;
    vecs.push_back(v);
  endtask

  // Tick until busy rises on dut_fix (entry into the delay phase).
  task automatic fix_wait_entry(input string nm);
    int n;
    n = 0;
    while (fix_if.busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(nm, {31'd0, fix_if.busy}, 32'd1);
  endtask

  // Count edges from delay entry until ready is seen.
  task automatic fix_edges_to_ready(output int n);
    n = 0;
    while (fix_if.ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    int          ok;
    int          exp_cnt;
    int          dvals[16];
    int          all_same;
    logic [3:0]  exp_rnd;

    rst_fix_l    = 1'b0;
    rst_rnd_l    = 1'b0;
    fix_if.start = 1'b0;
    fix_if.done  = 1'b0;
    rnd_if.start = 1'b0;
    rnd_if.done  = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_ready", {31'd0, fix_if.ready}, 32'd0);
    check("rst_busy", {31'd0, fix_if.busy}, 32'd0);
    check("rst_count", {16'd0, fix_if.race_count}, 32'd0);
    check("rst_timeout", {31'd0, fix_if.timeout}, 32'd0);
    check("rst_rnd_busy", {31'd0, rnd_if.busy}, 32'd0);

    // Handshake table: delay 4 -> ready 5 edges after entry.
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
    add(1'b1, 1'b1, 1'b0, 1'b1, 16'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'd2);

    rst_fix_l = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      fix_if.start = vecs[i].s;
      fix_if.done  = vecs[i].d;
      tick();
      check($sformatf("vec%0d_ready_busy_count", i),
            {14'd0, fix_if.ready, fix_if.busy, fix_if.race_count},
            {14'd0, vecs[i].exp_ready, vecs[i].exp_busy, vecs[i].exp_count});
    end

    // Mid-cycle reset while in the delay phase.
    fix_if.start = 1'b1; fix_if.done = 1'b0;
    tick();
    check("pre_reset_count", {16'd0, fix_if.race_count}, 32'd3);
    fix_if.start = 1'b0; fix_if.done = 1'b1;
    tick();
    fix_if.done = 1'b0;
    tick();
    tick();
    #3;
    rst_fix_l = 1'b0;
    #1;
    check("midrst_ready_busy_count",
          {15'd0, fix_if.ready, fix_if.busy, fix_if.race_count}, 32'd0);

    // start held high in IDLE for 50 cycles.
    fix_if.start = 1'b1;
    tick();
    rst_fix_l = 1'b1;
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fix_if.ready !== 1'b0 || fix_if.busy !== 1'b0) ok = 0;
    end
    check("start_held_idle", ok, 32'd1);
    fix_if.start = 1'b0;

    // Random races with random aborts against a counting model.
    exp_cnt = 0;
    for (int r = 0; r < 20; r++) begin
      fix_wait_entry($sformatf("rand%0d_entry", r));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) tick();
        if ($urandom_range(0, 1) == 1) fix_if.start = 1'b1;
        else fix_if.done = 1'b1;
        tick();
        check($sformatf("rand%0d_abort", r),
              {15'd0, fix_if.ready, fix_if.busy, fix_if.race_count},
              {15'd0, 1'b0, 1'b0, exp_cnt[15:0]});
        fix_if.start = 1'b0;
        fix_if.done  = 1'b0;
      end else begin
        fix_edges_to_ready(n);
        check($sformatf("rand%0d_delay_edges", r), n, 32'd5);
        ok = 1;
        repeat ($urandom_range(0, 4)) begin
          tick();
          if (fix_if.ready !== 1'b1) ok = 0;
        end
        check($sformatf("rand%0d_ready_held", r), ok, 32'd1);
        fix_if.start = 1'b1;
        tick();
        exp_cnt++;
        check($sformatf("rand%0d_accept", r),
              {15'd0, fix_if.ready, fix_if.race_count}, {15'd0, 1'b0, exp_cnt[15:0]});
        fix_if.start = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        fix_if.done = 1'b1;
        tick();
        check($sformatf("rand%0d_done_idle", r), {31'd0, fix_if.busy}, 32'd0);
        repeat ($urandom_range(0, 2)) tick();
        fix_if.done = 1'b0;
      end
    end

    // Watchdog behaviour in READY with start never asserted.
    fix_wait_entry("wd_entry");
    fix_edges_to_ready(n);
    check("wd_delay_edges", n, 32'd5);
`ifdef RACE_MARSHAL_TIMEOUT_EN
    ok = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (fix_if.ready === 1'b1) ok++;
      if (i < 8) check($sformatf("wd_no_early_timeout%0d", i), {31'd0, fix_if.timeout}, 32'd0);
    end
    check("wd_ready_high_ticks", ok, 32'd7);
    check("wd_timeout_pulse", {31'd0, fix_if.timeout}, 32'd1);
    check("wd_busy_idle", {31'd0, fix_if.busy}, 32'd0);
    check("wd_count_kept", {16'd0, fix_if.race_count}, exp_cnt);
    tick();
    check("wd_timeout_one_cycle", {31'd0, fix_if.timeout}, 32'd0);
`else
    ok = 1;
    n  = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fix_if.ready !== 1'b1) ok = 0;
      if (fix_if.timeout !== 1'b0) n = 0;
    end
    check("nowd_ready_stays", ok, 32'd1);
    check("nowd_timeout_zero", n, 32'd1);
`endif

    // 16 races on the randomised-delay instance: delay range and wrap.
    rst_rnd_l = 1'b1;
    exp_rnd   = 4'd0;
    for (int r = 0; r < 16; r++) begin
      n = 0;
      while (rnd_if.busy !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("rnd%0d_entry", r), {31'd0, rnd_if.busy}, 32'd1);
      n = 0;
      while (rnd_if.ready !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      dvals[r] = n - 1;
      check($sformatf("rnd%0d_d_in_4_19", r),
            {31'd0, (dvals[r] >= 4 && dvals[r] <= 19)}, 32'd1);
      repeat ($urandom_range(0, 3)) tick();
      rnd_if.start = 1'b1;
      tick();
      exp_rnd = exp_rnd + 4'd1;
      check($sformatf("rnd%0d_count", r), {28'd0, rnd_if.race_count}, {28'd0, exp_rnd});
      rnd_if.start = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      rnd_if.done = 1'b1;
      tick();
      repeat ($urandom_range(0, 1)) tick();
      rnd_if.done = 1'b0;
    end
    check("rnd_wrap_to_zero", {28'd0, rnd_if.race_count}, 32'd0);
    all_same = 1;
    for (int r = 1; r < 16; r++) begin
      if (dvals[r] != dvals[0]) all_same = 0;
    end
    check("rnd_delays_vary", all_same, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
